// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one req/gnt/rvalid data-memory port between the
// core LSU (requester 0) and a secondary master (requester 1). Round-robin
// on contention, selection held while memory stalls, and responses routed
// back in order through a small FIFO of 1-bit requester tags.
module data_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  r0_req_i,
  input  logic                  r1_req_i,
  output logic                  r0_gnt_o,
  output logic                  r1_gnt_o,
  input  logic [31:0]           r0_addr_i,
  input  logic [31:0]           r1_addr_i,
  input  logic                  r0_we_i,
  input  logic                  r1_we_i,
  input  logic [DATA_WIDTH-1:0] r0_wdata_i,
  input  logic [DATA_WIDTH-1:0] r1_wdata_i,
  output logic                  r0_rvalid_o,
  output logic                  r1_rvalid_o,
  output logic [DATA_WIDTH-1:0] r0_rdata_o,
  output logic [DATA_WIDTH-1:0] r1_rdata_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  output logic                  err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ARB, HOLD} state_e;

  state_e                     state_q, state_d;
  logic                       sel_q, last_q, err_q;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q;

  logic cand, cand_req, full, handshake, push, pop, head;

  assign full = (count_q == CW'(MAX_OUTSTANDING));

  // Candidate selection, memory request and next state. A full FIFO blocks
  // the request on the registered count, so a same-cycle pop does not help.
  always_comb begin
    cand     = 1'b0;
    cand_req = 1'b0;
    state_d  = ARB;
    if (state_q == HOLD) begin
      cand     = sel_q;
      cand_req = sel_q ? r1_req_i : r0_req_i;
    end else begin
      cand     = (r0_req_i && r1_req_i) ? ~last_q : r1_req_i;
      cand_req = r0_req_i | r1_req_i;
    end
    data_req_o = cand_req && !full;
    handshake  = data_req_o && data_gnt_i;
    if (handshake)                       state_d = ARB;
    else if (data_req_o)                 state_d = HOLD;
    else if (state_q == HOLD && cand_req) state_d = HOLD;  // stalled by full FIFO
  end

  assign data_addr_o  = cand ? r1_addr_i  : r0_addr_i;
  assign data_we_o    = cand ? r1_we_i    : r0_we_i;
  assign data_wdata_o = cand ? r1_wdata_i : r0_wdata_i;
  assign r0_gnt_o     = handshake && !cand;
  assign r1_gnt_o     = handshake &&  cand;

  assign push        = handshake;
  assign pop         = data_rvalid_i && (count_q != '0);
  assign head        = tag_q[rd_ptr_q];
  assign r0_rvalid_o = pop && !head;
  assign r1_rvalid_o = pop &&  head;
  assign r0_rdata_o  = data_rdata_i;
  assign r1_rdata_o  = data_rdata_i;
  assign err_o       = err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Arbitration state: last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d == HOLD) sel_q  <= cand;
      if (handshake)       last_q <= cand;
    end
  end

  // Response-routing tag FIFO; simultaneous push/pop keeps the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= cand;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          err_q <= 1'b0;
    else if (data_rvalid_i && count_q == '0) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Table-driven bench for data_mem_arbiter. Each row is one clock cycle of
// stimulus plus the expected combinational outputs; a tag scoreboard checks
// that responses are routed to requesters in grant order.
module tb_data_mem_arbiter;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        r0_req_i, r1_req_i, r0_gnt_o, r1_gnt_o;
  logic [31:0] r0_addr_i, r1_addr_i;
  logic        r0_we_i, r1_we_i;
  logic [31:0] r0_wdata_i, r1_wdata_i;
  logic        r0_rvalid_o, r1_rvalid_o;
  logic [31:0] r0_rdata_o, r1_rdata_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [31:0] data_wdata_o, data_rdata_i;
  logic        err_o;

  data_mem_arbiter #(.DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .r0_req_i(r0_req_i), .r1_req_i(r1_req_i),
    .r0_gnt_o(r0_gnt_o), .r1_gnt_o(r1_gnt_o),
    .r0_addr_i(r0_addr_i), .r1_addr_i(r1_addr_i),
    .r0_we_i(r0_we_i), .r1_we_i(r1_we_i),
    .r0_wdata_i(r0_wdata_i), .r1_wdata_i(r1_wdata_i),
    .r0_rvalid_o(r0_rvalid_o), .r1_rvalid_o(r1_rvalid_o),
    .r0_rdata_o(r0_rdata_o), .r1_rdata_o(r1_rdata_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit rst, r0q, r1q; logic [31:0] a0, a1; bit gnt, rv; logic [31:0] rd;
    bit dq; logic [31:0] ea; bit ewe, g0, g1, v0, v1, er;
  } vec_t;

  vec_t tbl[$];
  bit   sb_q[$];
  int   n_vec = 0, n_bad = 0;

  function automatic vec_t mk(bit rst, bit r0q, bit r1q, logic [31:0] a0,
      logic [31:0] a1, bit gnt, bit rv, logic [31:0] rd, bit dq,
      logic [31:0] ea, bit ewe, bit g0, bit g1, bit v0, bit v1, bit er);
    vec_t t;
    t = '{rst, r0q, r1q, a0, a1, gnt, rv, rd, dq, ea, ewe, g0, g1, v0, v1, er};
    return t;
  endfunction

  initial begin
    logic [39:0] act, exp_v;
    bit          tag;
    // rst r0 r1 a0 a1 gnt rv rdata | dreq addr we g0 g1 rv0 rv1 err
    // reset state, idle shows requester 0
    tbl.push_back(mk(1,0,0,32'h123,32'h456,0,0,0,          0,32'h123,1,0,0,0,0,0));
    // single requester read
    tbl.push_back(mk(0,1,0,32'h100,32'h0,1,0,0,            1,32'h100,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,32'h0,0,1,32'hDEADBEEF,   0,32'h0,1,0,0,1,0,0));
    // contention: alternate from r0 after reset
    tbl.push_back(mk(1,1,1,32'h10,32'h20,1,0,0,            1,32'h10,1,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h10,32'h20,1,1,32'h1111,     1,32'h20,0,0,1,1,0,0));
    tbl.push_back(mk(0,1,1,32'h10,32'h20,1,1,32'h2222,     1,32'h10,1,1,0,0,1,0));
    tbl.push_back(mk(0,1,1,32'h10,32'h20,1,1,32'h3333,     1,32'h20,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,32'h10,32'h20,0,1,32'h4444,     0,32'h10,1,0,0,0,1,0));
    // stall hold on r1
    tbl.push_back(mk(1,0,1,32'h300,32'h200,0,0,0,          1,32'h200,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h300,32'h200,0,0,0,          1,32'h200,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h300,32'h200,0,0,0,          1,32'h200,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h300,32'h200,1,0,0,          1,32'h200,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,32'h300,32'h200,1,0,0,          1,32'h300,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,32'h300,32'h200,0,1,32'hAAAA,   0,32'h300,1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,32'h300,32'h200,0,1,32'hBBBB,   0,32'h300,1,0,0,1,0,0));
    // FIFO full blocks; pop unblocks only next cycle
    tbl.push_back(mk(1,1,0,32'h40,32'h0,1,0,0,             1,32'h40,1,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h44,32'h0,1,0,0,             1,32'h44,1,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h48,32'h0,1,0,0,             0,32'h48,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h48,32'h0,1,1,32'h55,        0,32'h48,1,0,0,1,0,0));
    tbl.push_back(mk(0,1,0,32'h48,32'h0,1,0,0,             1,32'h48,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,32'h0,0,1,32'h66,         0,32'h0,1,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,32'h0,32'h0,0,1,32'h77,         0,32'h0,1,0,0,1,0,0));
    // spurious response: dropped, err sticky
    tbl.push_back(mk(0,0,0,32'h0,32'h0,0,1,32'h88,         0,32'h0,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,32'h0,0,0,0,              0,32'h0,1,0,0,0,0,1));
    tbl.push_back(mk(0,1,0,32'h50,32'h0,1,0,0,             1,32'h50,1,1,0,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,32'h0,0,1,32'h8,          0,32'h0,1,0,0,1,0,1));
    // reset mid-operation with one outstanding
    tbl.push_back(mk(1,1,0,32'h80,32'h0,1,0,0,             1,32'h80,1,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,32'h0,32'h0,0,1,32'h90,         0,32'h0,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,32'h0,0,0,0,              0,32'h0,1,0,0,0,0,1));
    tbl.push_back(mk(0,1,0,32'h84,32'h0,1,0,0,             1,32'h84,1,1,0,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,32'h0,0,1,32'h99,         0,32'h0,1,0,0,1,0,1));

    r0_req_i = 0; r1_req_i = 0; r0_addr_i = 0; r1_addr_i = 0;
    r0_we_i = 1; r1_we_i = 0; r0_wdata_i = 0; r1_wdata_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;

    foreach (tbl[i]) begin
      @(negedge clk_i);
      if (tbl[i].rst) begin
        rst_ni = 1'b0;
        sb_q.delete();
        #1 rst_ni = 1'b1;
      end
      r0_req_i = tbl[i].r0q;  r1_req_i = tbl[i].r1q;
      r0_addr_i = tbl[i].a0;  r1_addr_i = tbl[i].a1;
      r0_wdata_i = ~tbl[i].a0; r1_wdata_i = ~tbl[i].a1;
      data_gnt_i = tbl[i].gnt; data_rvalid_i = tbl[i].rv;
      data_rdata_i = tbl[i].rd;
      #2;
      act   = {data_req_o, data_addr_o, data_we_o, r0_gnt_o, r1_gnt_o,
               r0_rvalid_o, r1_rvalid_o, err_o};
      exp_v = {tbl[i].dq, tbl[i].ea, tbl[i].ewe, tbl[i].g0, tbl[i].g1,
               tbl[i].v0, tbl[i].v1, tbl[i].er};
      n_vec++;
      if (act !== exp_v || data_wdata_o !== ~tbl[i].ea) begin
        n_bad++;
        $display("FAIL vec%0d outputs: got %h wdata %h, want %h wdata %h",
                 i, act, data_wdata_o, exp_v, ~tbl[i].ea);
      end
      // scoreboard: pop expected routing tag on any observed response
      if (r0_rvalid_o || r1_rvalid_o) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL vec%0d route: rvalid %b%b with nothing expected",
                   i, r1_rvalid_o, r0_rvalid_o);
        end else begin
          tag = sb_q.pop_front();
          if ((r1_rvalid_o !== tag) || (r0_rvalid_o !== !tag) ||
              ((tag ? r1_rdata_o : r0_rdata_o) !== tbl[i].rd)) begin
            n_bad++;
            $display("FAIL vec%0d route: got rv1/rv0 %b%b data %h, want tag %0d data %h",
                     i, r1_rvalid_o, r0_rvalid_o,
                     tag ? r1_rdata_o : r0_rdata_o, tag, tbl[i].rd);
          end
        end
      end
      if (tbl[i].g0) sb_q.push_back(1'b0);
      if (tbl[i].g1) sb_q.push_back(1'b1);
    end

    @(negedge clk_i);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses still expected, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares the single data-memory port (req/gnt/rvalid protocol) between the core load/store unit (requester 0) and a secondary master such as a DMA or debug module (requester 1). It sits between the MEM-stage load/store path and the data memory. It applies round-robin arbitration and holds the selection stable while the memory stalls a request. It routes each response back to its originator through an in-order tag FIFO.

## Interface
- DATA_WIDTH, 32 (from riscv_cpu_pkg): data bus width.
- MAX_OUTSTANDING, 2: depth of the response-routing FIFO (≥1, power of two not required).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- r0_req_i / r1_req_i  in  1  request from requester 0 / 1.
- r0_gnt_o / r1_gnt_o  out  1  request accepted this cycle.
- r0_addr_i / r1_addr_i  in  32  byte address.
- r0_we_i / r1_we_i  in  1  write enable.
- r0_wdata_i / r1_wdata_i  in  DATA_WIDTH  write data.
- r0_rvalid_o / r1_rvalid_o  out  1  response for this requester.
- r0_rdata_o / r1_rdata_o  out  DATA_WIDTH  read data, valid only with the matching rvalid.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  memory grant.
- data_rvalid_i  in  1  memory response valid.
- data_addr_o  out  32  memory address.
- data_we_o  out  1  memory write enable.
- data_wdata_o  out  DATA_WIDTH  memory write data.
- data_rdata_i  in  DATA_WIDTH  memory read data.
- err_o  out  1  sticky protocol error: rvalid arrived with no outstanding request.

## Operation
- FSM with two states, ARB and HOLD. Registered state: state_q, sel_q (held requester), last_q (last granted requester), route FIFO (1-bit tags, count_q), err_q.
- ARB state:
  - Candidate is the only requester asserting req. If both request, the candidate is the one ≠ last_q.
  - data_req_o = (any req) && count_q < MAX_OUTSTANDING.
  - The candidate's addr/we/wdata are muxed to the memory outputs.
- HOLD state: the candidate is forced to sel_q regardless of the other requester; data_req_o follows the same count rule.
- Handshake = data_req_o && data_gnt_i. On handshake:
  - rN_gnt_o=1 for the candidate only.
  - Push candidate tag into the FIFO.
  - last_q ← candidate.
  - Next state ARB.
- data_req_o=1 without gnt: sel_q ← candidate, next state HOLD.
- Requesters must keep req/addr/we/wdata stable until gnt. A requester dropping req while held is a protocol violation. The arbiter then returns to ARB and does not flag it.
- On data_rvalid_i with count_q>0:
  - Pop the FIFO head.
  - r{head}_rvalid_o=1.
  - Both rdata outputs = data_rdata_i.
  - Writes receive rvalid as well.
- On data_rvalid_i with count_q==0: no rvalid is forwarded, and err_q ← 1. err_q is cleared only by reset.
- Push and pop in the same cycle: count unchanged, ordering preserved.
- FIFO full (count_q==MAX_OUTSTANDING): data_req_o=0 and no gnt. A pop in the same cycle does not unblock the request; the request is issued the following cycle.
- Unused gnt/rvalid outputs are 0.

## Timing
- Reset values: state ARB, last_q=1 (requester 0 wins the first tie), count_q=0, FIFO pointers 0, err_o=0.
  - All gnt/rvalid outputs 0.
  - data_req_o=0 while no req.
  - data_addr_o/we/wdata show requester 0 inputs when idle.
- req→data_req_o and data_gnt_i→rN_gnt_o: combinational, zero cycles.
- data_rvalid_i→rN_rvalid_o/rdata: combinational from the FIFO head, zero cycles.
- Earliest response: the cycle after the grant. Response latency is memory-defined; ordering is in-order.
- Throughput: one grant per cycle while the FIFO is not full, alternating under continuous contention.
- Reset mid-operation clears the FIFO and HOLD state. Responses to pre-reset requests that arrive afterwards are dropped and set err_o.

## Test plan
- Single requester: r0 read addr 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF → r0_gnt_o=1 in cycle 0, r0_rvalid_o=1 with r0_rdata_o=0xDEADBEEF in cycle 1, r1_rvalid_o=0.
- Contention: r0 and r1 request continuously, gnt always 1 → grants alternate r0,r1,r0,r1 starting with r0 after reset; rvalids route in the same order.
- Stall hold: r1 alone requests addr 0x200, then r0 raises req while gnt is held low for 3 cycles → data_addr_o stays 0x200, r1 granted on cycle 4, r0 granted next.
- FIFO full (MAX_OUTSTANDING=2): two grants, no rvalid → third request sees data_req_o=0. Rvalid pops one; the request issues the following cycle.
- Spurious response: rvalid with no outstanding request → no rN_rvalid_o, err_o rises and stays 1 until rst_ni asserted.
- Reset mid-operation: assert rst_ni with one outstanding request, release, then rvalid → dropped, err_o=1, next r0 request granted normally.
